video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Generates the pixel position counters and raster timing that drive the arcade core's video, CPU and sound stages.
- Runs from the 48 MHz master clock and derives a one-in-eight pixel enable, giving a 6 MHz pixel rate.
- Produces PH/PV, blanking and sync, plus a once-per-frame vblank-start pulse used for the CPU interrupt.
- Supports signed screen-position offsets that are applied only at frame boundaries.

Parameters:
- HTOTAL, 384: pixel clocks per line (PH counts 0..HTOTAL-1).
- VTOTAL, 264: lines per frame (PV counts 0..VTOTAL-1).
- HACT_START, 8: first visible PH.
- HACT_END, 248: first blanked PH after the visible area.
- VACT_START, 16: first visible PV.
- VACT_END, 240: first blanked PV after the visible area; also the VFRM trigger line.
- HS_START, 288: nominal HSYN start PH.
- HS_WIDTH, 32: HSYN width in pixels.
- VS_START, 248: nominal VSYN start PV.
- VS_WIDTH, 8: VSYN width in lines.
- Constraint: HS_START-8 ≥ HACT_END and HS_START+7+HS_WIDTH ≤ HTOTAL. The same rule applies to VS against VACT_END/VTOTAL.

Ports:
- clk48M  in  1  master clock; the only clock in the block.
- reset  in  1  asynchronous, active-high.
- HOFFS  in  4  signed horizontal sync offset, -8..+7 pixels.
- VOFFS  in  4  signed vertical sync offset, -8..+7 lines.
- PCE  out  1  pixel clock enable, one clk48M cycle wide, every 8 cycles.
- PH  out  9  horizontal pixel counter.
- PV  out  9  vertical line counter.
- HBLK  out  1  horizontal blank, 1 = blanked.
- VBLK  out  1  vertical blank, 1 = blanked.
- HSYN  out  1  horizontal sync, active-high.
- VSYN  out  1  vertical sync, active-high.
- VFRM  out  1  vblank-start pulse, one clk48M cycle wide.

Behaviour:
- All outputs are registered on clk48M.
- Next values are computed combinationally and registered, so flags always match the PH/PV registered alongside them.
- Reset (asynchronous, any time, including mid-line):
  - divider=0, PH=0, PV=0, PCE=0, VFRM=0, HSYN=0, VSYN=0, HBLK=1, VBLK=1.
  - Latched offsets are cleared to 0.
  - After release, counting restarts from the origin. No partial-line state survives.
- Divider:
  - 3-bit free-running counter; it wraps 7→0.
  - PCE=1 in the cycle where the divider equals 7. The first PCE is the 8th clk48M edge after reset release.
- Counter advance happens in the cycle where the divider equals 7, at the same edge PCE is registered high:
  - PH increments; at HTOTAL-1 it wraps to 0 and PV increments.
  - PV wraps from VTOTAL-1 to 0 on the same edge PH wraps.
  - Frame period = HTOTAL*VTOTAL*8 = 811008 clk48M cycles.
- Blanking:
  - HBLK = !(HACT_START ≤ PH < HACT_END).
  - VBLK = !(VACT_START ≤ PV < VACT_END).
  - Both are evaluated on the next PH/PV values and registered with them.
- Offset latch:
  - HOFFS/VOFFS are sampled and sign-extended to 9 bits only on the advance edge where PH and PV both wrap to 0.
  - Changes mid-frame have no effect until the next frame origin.
- Sync:
  - HSYN=1 while hs0 ≤ PH < hs0+HS_WIDTH, where hs0 = HS_START + latched HOFFS.
  - VSYN=1 while vs0 ≤ PV < vs0+VS_WIDTH, where vs0 = VS_START + latched VOFFS.
  - VSYN changes only together with PV, i.e. at the PH wrap.
- VFRM:
  - Equals 1 for exactly one clk48M cycle: the cycle after the advance edge on which PV becomes VACT_END.
  - It coincides with the registered PCE of that edge.
  - Exactly once per frame; never asserted during reset.
- Held-off behaviour: none. The block has no pause input and always counts; pausing is handled downstream.

Test Plan:
- Assert reset for 5 cycles, then release → outputs hold reset values for 7 cycles; first PCE on the 8th clk48M edge with PH=1, PV=0.
- Run 3072 cycles (one line) → PH 383 wraps to 0 and PV steps to 1 on the 384th PCE; PCE spacing is always exactly 8.
- Run one line past PV=15 → VBLK falls when PV becomes 16. HBLK falls when PH becomes 8 and rises when PH becomes 248. HSYN is high for PH 288..319 (256 cycles) with HOFFS=0.
- Run 2 frames → VFRM pulses exactly twice, 811008 cycles apart, each when PV becomes 240 and PH=0. VSYN is high for PV 248..255; PV wraps 263→0.
- Set HOFFS=4'b1000 (-8) and VOFFS=4'd7 mid-frame → current frame keeps HSYN at 288..319. From the next frame, HSYN is at 280..311 and VSYN at PV 255..262.
- Assert reset asynchronously at PH=100, PV=50, between clk48M edges → outputs reach reset values immediately without a clock edge. Latched offsets return to 0, so the next frame has HSYN at 288.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: 1-in-8 pixel enable from the master clock, PH/PV
// counters, blanking, sync with frame-latched signed offsets and a
// once-per-frame vblank-start pulse.
module video_timing_gen #(
  parameter int unsigned HTOTAL     = 384,
  parameter int unsigned VTOTAL     = 264,
  parameter int unsigned HACT_START = 8,
  parameter int unsigned HACT_END   = 248,
  parameter int unsigned VACT_START = 16,
  parameter int unsigned VACT_END   = 240,
  parameter int unsigned HS_START   = 288,
  parameter int unsigned HS_WIDTH   = 32,
  parameter int unsigned VS_START   = 248,
  parameter int unsigned VS_WIDTH   = 8
) (
  input  logic       clk48M,
  input  logic       reset,
  input  logic [3:0] HOFFS,
  input  logic [3:0] VOFFS,
  output logic       PCE,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYN,
  output logic       VSYN,
  output logic       VFRM
);

  localparam int unsigned CW = 9;
  localparam int unsigned SW = 10;

  localparam logic [CW-1:0] PH_LAST   = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] PV_LAST   = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] PV_VFRM   = CW'(VACT_END - 1);
  localparam logic [CW-1:0] H_ACT_S   = CW'(HACT_START);
  localparam logic [CW-1:0] H_ACT_E   = CW'(HACT_END);
  localparam logic [CW-1:0] V_ACT_S   = CW'(VACT_START);
  localparam logic [CW-1:0] V_ACT_E   = CW'(VACT_END);
  localparam logic [SW-1:0] H_SYNC_S  = SW'(HS_START);
  localparam logic [SW-1:0] H_SYNC_W  = SW'(HS_WIDTH);
  localparam logic [SW-1:0] V_SYNC_S  = SW'(VS_START);
  localparam logic [SW-1:0] V_SYNC_W  = SW'(VS_WIDTH);

  logic [2:0]    div_q,   div_d;
  logic [CW-1:0] ph_q,    ph_d;
  logic [CW-1:0] pv_q,    pv_d;
  logic [CW-1:0] hoffs_q, hoffs_d;
  logic [CW-1:0] voffs_q, voffs_d;
  logic          pce_q,   pce_d;
  logic          hblk_q,  hblk_d;
  logic          vblk_q,  vblk_d;
  logic          hsyn_q,  hsyn_d;
  logic          vsyn_q,  vsyn_d;
  logic          vfrm_q,  vfrm_d;

  logic          adv;
  logic          ph_wrap;
  logic          pv_wrap;
  logic [SW-1:0] hs0, hs1, vs0, vs1;

  // Next-state: divider, counters, frame-origin offset latch, and flags
  // evaluated on the next PH/PV so they register in step with them.
  always_comb begin
    adv     = (div_q == 3'd7);
    ph_wrap = (ph_q == PH_LAST);
    pv_wrap = (pv_q == PV_LAST);
    div_d   = div_q + 3'd1;
    ph_d    = ph_q;
    pv_d    = pv_q;
    hoffs_d = hoffs_q;
    voffs_d = voffs_q;

    if (adv) begin
      if (ph_wrap) begin
        ph_d = '0;
        if (pv_wrap) begin
          pv_d    = '0;
          hoffs_d = {{(CW-4){HOFFS[3]}}, HOFFS};
          voffs_d = {{(CW-4){VOFFS[3]}}, VOFFS};
        end else begin
          pv_d = pv_q + CW'(1);
        end
      end else begin
        ph_d = ph_q + CW'(1);
      end
    end

    // Sync window bounds in 10 bits so a negative offset wraps cleanly.
    hs0 = H_SYNC_S + {hoffs_d[CW-1], hoffs_d};
    hs1 = hs0 + H_SYNC_W;
    vs0 = V_SYNC_S + {voffs_d[CW-1], voffs_d};
    vs1 = vs0 + V_SYNC_W;

    pce_d  = adv;
    hblk_d = !((ph_d >= H_ACT_S) && (ph_d < H_ACT_E));
    vblk_d = !((pv_d >= V_ACT_S) && (pv_d < V_ACT_E));
    hsyn_d = ({1'b0, ph_d} >= hs0) && ({1'b0, ph_d} < hs1);
    vsyn_d = ({1'b0, pv_d} >= vs0) && ({1'b0, pv_d} < vs1);
    vfrm_d = adv && ph_wrap && (pv_q == PV_VFRM);
  end

  // State and output registers; async reset returns to the raster origin.
  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      ph_q    <= '0;
      pv_q    <= '0;
      hoffs_q <= '0;
      voffs_q <= '0;
      pce_q   <= 1'b0;
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= 1'b0;
      vsyn_q  <= 1'b0;
      vfrm_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      ph_q    <= ph_d;
      pv_q    <= pv_d;
      hoffs_q <= hoffs_d;
      voffs_q <= voffs_d;
      pce_q   <= pce_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      hsyn_q  <= hsyn_d;
      vsyn_q  <= vsyn_d;
      vfrm_q  <= vfrm_d;
    end
  end

  assign PCE  = pce_q;
  assign PH   = ph_q;
  assign PV   = pv_q;
  assign HBLK = hblk_q;
  assign VBLK = vblk_q;
  assign HSYN = hsyn_q;
  assign VSYN = vsyn_q;
  assign VFRM = vfrm_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a reduced raster; expected outputs come from
// the elapsed clock count since reset release and the frame-latched offsets.
module tb_video_timing_gen;

  localparam int HT    = 34;
  localparam int VT    = 27;
  localparam int HAS   = 3;
  localparam int HAE   = 16;
  localparam int VAS   = 2;
  localparam int VAE   = 10;
  localparam int HSS   = 24;
  localparam int HSW   = 3;
  localparam int VSS   = 18;
  localparam int VSW   = 2;
  localparam int FRAME = HT * VT * 8;

  logic       clk48M = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] HOFFS  = 4'd0;
  logic [3:0] VOFFS  = 4'd0;
  logic       PCE, HBLK, VBLK, HSYN, VSYN, VFRM;
  logic [8:0] PH, PV;

  video_timing_gen #(
    .HTOTAL(HT), .VTOTAL(VT), .HACT_START(HAS), .HACT_END(HAE),
    .VACT_START(VAS), .VACT_END(VAE), .HS_START(HSS), .HS_WIDTH(HSW),
    .VS_START(VSS), .VS_WIDTH(VSW)
  ) dut (
    .clk48M(clk48M), .reset(reset), .HOFFS(HOFFS), .VOFFS(VOFFS),
    .PCE(PCE), .PH(PH), .PV(PV), .HBLK(HBLK), .VBLK(VBLK),
    .HSYN(HSYN), .VSYN(VSYN), .VFRM(VFRM)
  );

  always #5 clk48M = ~clk48M;

  localparam logic [23:0] RST_VEC = {1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;
  int k      = 0;
  bit in_rst = 1'b1;
  int lh     = 0;
  int lv     = 0;
  int hs_rise, vs_rise;
  bit prev_hs, prev_vs;
  int vfrm_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: position = clock edges since release / 8, folded into the raster.
  function automatic logic [23:0] exp_vec();
    int n, p, ph, pv;
    bit pce, hb, vb, hs, vs, vf;
    if (in_rst) return RST_VEC;
    n   = k / 8;
    p   = n % (HT * VT);
    ph  = p % HT;
    pv  = p / HT;
    pce = (k > 0) && (k % 8 == 0);
    hb  = !(ph >= HAS && ph < HAE);
    vb  = !(pv >= VAS && pv < VAE);
    hs  = (ph >= HSS + lh) && (ph < HSS + lh + HSW);
    vs  = (pv >= VSS + lv) && (pv < VSS + lv + VSW);
    vf  = pce && (ph == 0) && (pv == VAE);
    return {pce, 9'(ph), 9'(pv), hb, vb, hs, vs, vf};
  endfunction

  function automatic logic [23:0] obs_vec();
    return {PCE, PH, PV, HBLK, VBLK, HSYN, VSYN, VFRM};
  endfunction

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk48M);
    cyc++;
    if (!in_rst) begin
      k++;
      if ((k % 8 == 0) && ((k / 8) % (HT * VT) == 0)) begin
        lh = int'($signed(HOFFS));
        lv = int'($signed(VOFFS));
      end
    end
    @(negedge clk48M);
    check("raster", 32'(obs_vec()), 32'(exp_vec()));
    if (HSYN && !prev_hs) hs_rise = int'(PH);
    if (VSYN && !prev_vs) vs_rise = int'(PV);
    if (VFRM) vfrm_t.push_back(cyc);
    prev_hs = HSYN;
    prev_vs = VSYN;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_rise();
    hs_rise = -1;
    vs_rise = -1;
  endtask

  initial begin
    clear_rise();
    prev_hs = 1'b0;
    prev_vs = 1'b0;

    // Reset held for 5 cycles.
    steps(5);
    check("reset_state", 32'(obs_vec()), 32'(RST_VEC));
    reset  = 1'b0;
    in_rst = 1'b0;
    k      = 0;

    // Seven edges of reset-like outputs, first PCE on the 8th edge.
    steps(7);
    check("pre_pce_idle", 32'({PCE, PH}), 32'({1'b0, 9'd0}));
    step();
    check("first_pce", 32'({PCE, PH, PV}), 32'({1'b1, 9'd1, 9'd0}));

    // Two frames at zero offset: VFRM twice, one frame apart.
    vfrm_t.delete();
    clear_rise();
    steps(2 * FRAME);
    check("vfrm_count", 32'(vfrm_t.size()), 32'd2);
    if (vfrm_t.size() == 2)
      check("vfrm_spacing", 32'(vfrm_t[1] - vfrm_t[0]), 32'(FRAME));
    check("hs_rise_nominal", 32'(hs_rise), 32'(HSS));
    check("vs_rise_nominal", 32'(vs_rise), 32'(VSS));

    // Offsets changed mid-frame: current frame unaffected.
    HOFFS = 4'b1000;
    VOFFS = 4'd7;
    clear_rise();
    steps(FRAME - 16);
    check("hs_rise_hold", 32'(hs_rise), 32'(HSS));
    check("vs_rise_hold", 32'(vs_rise), 32'(VSS));

    // Following frame uses the latched offsets.
    clear_rise();
    steps(FRAME);
    check("hs_rise_offs", 32'(hs_rise), 32'(HSS - 8));
    check("vs_rise_offs", 32'(vs_rise), 32'(VSS + 7));

    // Random offset changes at random points in the raster.
    for (int i = 0; i < 40; i++) begin
      steps(int'($urandom_range(50, 400)));
      HOFFS = 4'($urandom);
      VOFFS = 4'($urandom);
    end

    // Asynchronous reset mid-line, between clock edges.
    HOFFS = 4'b1000;
    VOFFS = 4'd7;
    for (int i = 0; i < 2 * FRAME && !(PH == 9'd20 && PV == 9'd5); i++) step();
    check("reach_pos", 32'({PH, PV}), 32'({9'd20, 9'd5}));
    #2;
    reset  = 1'b1;
    in_rst = 1'b1;
    #1;
    check("async_reset", 32'(obs_vec()), 32'(RST_VEC));
    steps(3);
    reset  = 1'b0;
    in_rst = 1'b0;
    k      = 0;
    lh     = 0;
    lv     = 0;

    // First frame after reset runs with cleared offsets.
    clear_rise();
    steps(FRAME - 16);
    check("hs_rise_after_rst", 32'(hs_rise), 32'(HSS));
    check("vs_rise_after_rst", 32'(vs_rise), 32'(VSS));
    clear_rise();
    steps(FRAME);
    check("hs_rise_relatch", 32'(hs_rise), 32'(HSS - 8));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
